// File: rtl/boot_pkg.sv
// Shared types and default widths for the instruction-cache boot loader.
package boot_pkg;

  localparam int BOOT_ADDR_W = 8;
  localparam int BOOT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } boot_state_t;

endpackage

// File: rtl/icache_boot_loader.sv
// Streams program words from a valid/ready source into the icache boot port,
// holding the core in boot mode until the last word is written.
module icache_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W      = BOOT_ADDR_W,
  parameter int DATA_W      = BOOT_DATA_W,
  parameter int RELEASE_DLY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              boot_up,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [DATA_W-1:0] boot_datai,
  output logic              boot_web,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int              CNT_W   = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DLY - 1);

  boot_state_t      state, state_n;
  logic [ADDR_W:0]  len;
  logic [ADDR_W:0]  idx;
  logic [ADDR_W:0]  idx_inc;
  logic [CNT_W-1:0] rel_cnt;
  logic             start_ok;
  logic             rel_last;

  assign start_ok = start && (prog_len != '0) && (prog_len <= MAX_LEN);
  assign idx_inc  = idx + (ADDR_W+1)'(1);
  assign rel_last = (rel_cnt == REL_LAST);
  assign s_ready  = (state == LOAD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: next state defaults to the current state before the case, so no
  // path through this block leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_ok) state_n = LOAD;
      LOAD: begin
        if (abort)        state_n = IDLE;
        else if (s_valid) state_n = WRITE;
      end
      WRITE: begin
        if (abort)              state_n = IDLE;
        else if (idx_inc == len) state_n = RELEASE;
        else                    state_n = LOAD;
      end
      RELEASE: if (rel_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len          <= '0;
      idx          <= '0;
      rel_cnt      <= '0;
      boot_up      <= 1'b0;
      boot_addr    <= '0;
      boot_datai   <= '0;
      boot_web     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      busy <= (state_n != IDLE);
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            len          <= prog_len;
            idx          <= '0;
            words_loaded <= '0;
            boot_up      <= 1'b1;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          // An abort takes precedence over a word offered in the same cycle.
          if (abort) begin
            boot_up <= 1'b0;
            err     <= 1'b1;
          end else if (s_valid) begin
            boot_datai <= s_data;
            boot_addr  <= idx[ADDR_W-1:0];
            boot_web   <= 1'b0;
          end
        end
        WRITE: begin
          // The write strobe is already low this cycle, so it counts even on abort.
          boot_web     <= 1'b1;
          idx          <= idx_inc;
          words_loaded <= idx_inc;
          rel_cnt      <= '0;
          if (abort) begin
            boot_up <= 1'b0;
            err     <= 1'b1;
          end
        end
        RELEASE: begin
          if (rel_last) begin
            boot_up <= 1'b0;
            done    <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_boot_loader.sv
// Self-checking bench: drives directed load scenarios with randomized stream data
// and compares the observed icache writes against the words the source handed over.
module tb_icache_boot_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RLD    = 2;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready, boot_up, boot_web, busy, done, err;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] boot_datai;
  logic [ADDR_W:0]   words_loaded;

  icache_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RELEASE_DLY(RLD)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_len(prog_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .boot_up(boot_up),
    .boot_addr(boot_addr), .boot_datai(boot_datai), .boot_web(boot_web),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               wr_q[$];
  logic [DATA_W-1:0] src_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_err   = 0;

  // Passive observer of the icache port and the pulse outputs.
  always @(negedge clk) begin
    if (boot_web === 1'b0) wr_q.push_back('{addr: boot_addr, data: boot_datai});
    if (done === 1'b1) n_done++;
    if (err === 1'b1)  n_err++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_src(input int n, input bit rnd);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(rnd ? $urandom : 32'hA0 + i);
  endtask

  // Called at posedge+1; issues a one-cycle start.
  task automatic kick(input logic [ADDR_W:0] len);
    prog_len = len;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Source model: hands over src_q in order until done/err, optional abort right
  // after abort_at words were accepted, optional stray start during LOAD.
  task automatic stream(input int n, input bit rnd, input int abort_at, input bit poke,
                        output int cyc, output int sent);
    bit fin = 0, aborted = 0, poked = 0;
    cyc = 0; sent = 0;
    while (!fin && cyc < BUDGET) begin
      start = 1'b0; abort = 1'b0;
      s_valid = (sent < n) && !(abort_at >= 0 && sent >= abort_at) &&
                (!rnd || $urandom_range(0, 1) == 1);
      s_data  = (sent < src_q.size()) ? src_q[sent] : $urandom;
      if (abort_at >= 0 && sent == abort_at && !aborted) begin
        abort = 1'b1; aborted = 1;
      end
      if (poke && !poked && sent >= 1 && s_ready === 1'b1) begin
        start = 1'b1; prog_len = 9'd1; poked = 1;
      end
      @(negedge clk); cyc++;
      if (cyc == 1) check("boot_up_after_start", boot_up, 1'b1);
      if (s_valid && s_ready === 1'b1) sent++;
      if (done === 1'b1) begin
        fin = 1; check("boot_up_low_at_done", boot_up, 1'b0);
      end
      if (err === 1'b1) fin = 1;
      @(posedge clk); #1;
    end
    if (!fin) check("stream_timeout", 1'b0, 1'b1);
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_nwrites"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check({tag, "_addr"}, wr_q[i].addr, i);
      check({tag, "_data"}, wr_q[i].data, src_q[i]);
    end
  endtask

  task automatic bad_len(input logic [ADDR_W:0] len);
    int e0 = n_err;
    kick(len);
    @(negedge clk);
    check("bad_len_err", err, 1'b1);
    check("bad_len_boot_up", boot_up, 1'b0);
    check("bad_len_busy", busy, 1'b0);
    check("bad_len_web", boot_web, 1'b1);
    @(posedge clk); #1;
    check("bad_len_err_once", n_err - e0, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc, sent, d0, e0, c;
    bit found;
    // Reset state
    #12;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_boot_up", boot_up, 1'b0);
    check("rst_boot_addr", boot_addr, '0);
    check("rst_boot_datai", boot_datai, '0);
    check("rst_boot_web", boot_web, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_words_loaded", words_loaded, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: four words back-to-back
    fill_src(4, 0); wr_q.delete(); d0 = n_done;
    kick(9'd4);
    stream(4, 0, -1, 0, cyc, sent);
    check("t1_cycles_to_done", cyc, 2 * 4 + RLD + 1);
    check_writes("t1", 4);
    check("t1_words_loaded", words_loaded, 4);
    check("t1_done_once", n_done - d0, 1);
    check("t1_busy_after", busy, 1'b0);

    // 2: full icache with a randomly stalling source
    fill_src(256, 1); wr_q.delete(); d0 = n_done;
    kick(9'd256);
    stream(256, 1, -1, 0, cyc, sent);
    check_writes("t2", 256);
    check("t2_words_loaded", words_loaded, 256);
    check("t2_done_once", n_done - d0, 1);

    // 3: illegal lengths
    wr_q.delete();
    bad_len(9'd0);
    bad_len(9'd257);
    bad_len(9'd511);
    check("t3_no_writes", wr_q.size(), 0);

    // 4: abort coincident with the third write
    fill_src(8, 1); wr_q.delete(); d0 = n_done; e0 = n_err;
    kick(9'd8);
    stream(8, 0, 3, 0, cyc, sent);
    check("t4_err_pulse", err, 1'b0);
    check("t4_err_once", n_err - e0, 1);
    check_writes("t4", 3);
    check("t4_boot_up", boot_up, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_words_loaded", words_loaded, 3);
    check("t4_no_done", n_done - d0, 0);

    // 5: asynchronous reset during the write of word 2
    fill_src(4, 1); wr_q.delete();
    kick(9'd4);
    s_valid = 1'b1; sent = 0; found = 0; c = 0;
    while (!found && c < 40) begin
      s_data = src_q[sent < 4 ? sent : 3];
      @(negedge clk); c++;
      if (s_ready === 1'b1) sent++;
      @(posedge clk); #1;
      if (boot_web === 1'b0 && boot_addr === 8'd2) found = 1;
    end
    check("t5_reached_write2", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_web", boot_web, 1'b1);
    check("t5_async_boot_up", boot_up, 1'b0);
    check("t5_async_busy", busy, 1'b0);
    check("t5_async_s_ready", s_ready, 1'b0);
    s_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("t5_idle_s_ready", s_ready, 1'b0);
    check("t5_idle_busy", busy, 1'b0);
    check("t5_idle_words", words_loaded, '0);

    // 6: stray start during LOAD is ignored
    fill_src(4, 1); wr_q.delete(); d0 = n_done; e0 = n_err;
    kick(9'd4);
    stream(4, 1, -1, 1, cyc, sent);
    check_writes("t6", 4);
    check("t6_words_loaded", words_loaded, 4);
    check("t6_done_once", n_done - d0, 1);
    check("t6_no_err", n_err - e0, 0);
    repeat (4) @(posedge clk);
    #1 check("t6_stays_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
